// File: rtl/mem_arb_pkg.sv
// Shared constants, types and width helpers for the banked memory arbiter.
package mem_arb_pkg;

  localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'hFF00;
  localparam int unsigned ARB_FIXED_BIT     = 0;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Index width for n items; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Per-resource arbiter: round-robin or fixed priority, one-hot grant.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         fixed_mode,
  output logic [N-1:0] grant
);

  localparam int unsigned IdxW = idx_width(N);

  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant        = '0;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    idx          = 0;
    if (fixed_mode) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !found) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      // Search starts one past the previous winner and wraps.
      for (int k = 1; k <= N; k++) begin
        idx = (32'(last_grant_q) + 32'(k)) % N;
        if (req[idx] && !found) begin
          grant[idx]   = 1'b1;
          found        = 1'b1;
          last_grant_d = idx[IdxW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= IdxW'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Multi-port banked memory with per-bank arbitration and a control register.
// Optional MEM_ARB_PERF_EN adds per-bank 16-bit conflict counters.
module mem_bank_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned           NUM_PORTS  = 4,
  parameter int unsigned           NUM_BANKS  = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           BANK_ROWS  = 256,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = ADDR_WIDTH'(CTRL_ADDR_DEFAULT)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [DATA_WIDTH-1:0]            ctrl_reg
);

  localparam int unsigned BSEL    = idx_width(NUM_BANKS);
  localparam int unsigned ROWW    = idx_width(BANK_ROWS);
  localparam int unsigned NUM_RES = NUM_BANKS + 1;

  function automatic logic is_ctrl_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef MEM_ARB_PERF_EN
    logic [ADDR_WIDTH-1:0] off;
    off = a - CTRL_ADDR;
    return off <= ADDR_WIDTH'(NUM_BANKS);
`else
    return a == CTRL_ADDR;
`endif
  endfunction

  logic [ADDR_WIDTH-1:0] addr_p  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_p [NUM_PORTS];
  logic [BSEL-1:0]       bank_p  [NUM_PORTS];
  logic [ROWW-1:0]       row_p   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  is_ctrl;
  logic [NUM_PORTS-1:0]  res_req [NUM_RES];
  logic [NUM_PORTS-1:0]  res_gnt [NUM_RES];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_p[p]  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_p[p] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      bank_p[p]  = addr_p[p][BSEL-1:0];
      row_p[p]   = addr_p[p][BSEL +: ROWW];
      is_ctrl[p] = is_ctrl_addr(addr_p[p]);
    end
    for (int r = 0; r < NUM_BANKS; r++) begin
      res_req[r] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        res_req[r][p] = req_valid[p] & ~is_ctrl[p] & (bank_p[p] == BSEL'(r));
      end
    end
    res_req[NUM_BANKS] = req_valid & is_ctrl;
  end

  logic [DATA_WIDTH-1:0] ctrl_q;
  arb_mode_e             arb_mode;
  logic                  fixed_mode;

  assign arb_mode   = arb_mode_e'(ctrl_q[ARB_FIXED_BIT]);
  assign fixed_mode = (arb_mode == ARB_FIXED);

  // The last arbiter serves the control resource and is always fixed priority.
  for (genvar r = 0; r < NUM_RES; r++) begin : g_arb
    rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (res_req[r]),
      .fixed_mode ((r == NUM_BANKS) ? 1'b1 : fixed_mode),
      .grant      (res_gnt[r])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int r = 0; r < NUM_RES; r++) req_ready |= res_gnt[r];
  end

  logic [NUM_BANKS-1:0]  bank_we;
  logic [ROWW-1:0]       bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] mem        [NUM_BANKS][BANK_ROWS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = 1'b0;
      bank_row[b]   = '0;
      bank_wdata[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (res_gnt[b][p]) begin
          bank_we[b]    = req_we[p];
          bank_row[b]   = row_p[p];
          bank_wdata[b] = wdata_p[p];
        end
      end
      bank_rdata[b] = mem[b][bank_row[b]];
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) mem[b][bank_row[b]] <= bank_wdata[b];
    end
  end

  logic [ADDR_WIDTH-1:0] ctrl_addr;
  logic [DATA_WIDTH-1:0] ctrl_wdata, ctrl_rdata;
  logic                  ctrl_we, ctrl_wr;

  always_comb begin
    ctrl_addr  = CTRL_ADDR;
    ctrl_wdata = '0;
    ctrl_we    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (res_gnt[NUM_BANKS][p]) begin
        ctrl_addr  = addr_p[p];
        ctrl_wdata = wdata_p[p];
        ctrl_we    = req_we[p];
      end
    end
  end

  assign ctrl_wr = (|res_gnt[NUM_BANKS]) & ctrl_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (ctrl_wr && (ctrl_addr == CTRL_ADDR)) begin
      ctrl_q <= ctrl_wdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0]           cnt_q [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] ctrl_off;
  logic [BSEL-1:0]       perf_idx;

  assign ctrl_off   = ctrl_addr - CTRL_ADDR;
  assign perf_idx   = BSEL'(ctrl_off - ADDR_WIDTH'(1));
  assign ctrl_rdata = (ctrl_off == '0) ? ctrl_q : DATA_WIDTH'(cnt_q[perf_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (ctrl_wr && (ctrl_off != '0) && (perf_idx == BSEL'(b))) begin
          cnt_q[b] <= '0;
        end else if (($countones(res_req[b]) >= 2) && (cnt_q[b] != 16'hFFFF)) begin
          cnt_q[b] <= cnt_q[b] + 16'd1;
        end
      end
    end
  end
`else
  assign ctrl_rdata = ctrl_q;
`endif

  logic [NUM_PORTS-1:0]            rd_accept;
  logic [DATA_WIDTH-1:0]           rd_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]            rsp_valid_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_q;

  always_comb begin
    rd_accept = req_ready & ~req_we;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_data[p] = is_ctrl[p] ? ctrl_rdata : bank_rdata[bank_p[p]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rd_accept;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_accept[p]) rsp_rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_data[p];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ctrl_reg  = ctrl_q;

endmodule
